// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared widths and the ALU operation encoding for the RV32I datapath
//
// Purpose : data widths, register count and the alu_op_e encoding, shared by
//           the ALU and the core top.
// Ports   : none (package)
package rv32i_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 32;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_A = 4'd10,
    ALU_PASS_B = 4'd11,
    ALU_EQ     = 4'd12,
    ALU_NE     = 4'd13,
    ALU_GE     = 4'd14,
    ALU_GEU    = 4'd15
  } alu_op_e;

  // Widen a single compare bit to a full XLEN result of 0 or 1.
  function automatic logic [XLEN-1:0] bool_to_word(input logic b);
    return {{(XLEN-1){1'b0}}, b};
  endfunction

endpackage

// File: rtl/rv32i_alu.sv
// rtl/rv32i_alu.sv - combinational 16-function ALU
//
// Purpose : computes result = op(a, b); shift amount is b[4:0].
// Ports   : a, b   in  XLEN   operands
//           op     in  alu_op_e operation select
//           result out XLEN   operation result
//           zero   out 1      result == 0
module rv32i_alu
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [4:0] w_shamt;
  logic       w_lt_s;
  logic       w_lt_u;
  logic       w_eq;

  assign w_shamt = b[4:0];
  assign w_lt_s  = $signed(a) < $signed(b);
  assign w_lt_u  = a < b;
  assign w_eq    = a == b;

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << w_shamt;
      ALU_SLT:    result = bool_to_word(w_lt_s);
      ALU_SLTU:   result = bool_to_word(w_lt_u);
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> w_shamt;
      ALU_SRA:    result = $unsigned($signed(a) >>> w_shamt);
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_PASS_A: result = a;
      ALU_PASS_B: result = b;
      ALU_EQ:     result = bool_to_word(w_eq);
      ALU_NE:     result = bool_to_word(!w_eq);
      ALU_GE:     result = bool_to_word(!w_lt_s);
      ALU_GEU:    result = bool_to_word(!w_lt_u);
      default:    result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rv32i_core_top.sv
// rtl/rv32i_core_top.sv - RV32I datapath harness: register file, ALU and PC
//
// Purpose : 32x32 register file (x0 reads as zero), ALU on the two read ports,
//           and a PC that advances by 4 or loads the ALU result on jump.
// Ports   : clk        in  1     rising-edge clock
//           areset_n   in  1     asynchronous active-low reset
//           wdata_in   in  XLEN  register write data
//           alu_test   in  4     ALU operation (alu_op_e)
//           ra0, ra1   in  5     read addresses (ALU operands A, B)
//           wa         in  5     write address
//           wr_en      in  1     register write enable
//           jump       in  1     load PC from ALU result
//           rd0, rd1   out XLEN  read data
//           alu_result out XLEN  ALU result
//           alu_zero   out 1     ALU result is zero
//           pc         out XLEN  program counter
module rv32i_core_top
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      areset_n,
  input  logic [XLEN-1:0]           wdata_in,
  input  logic [3:0]                alu_test,
  input  logic [REG_ADDR_WIDTH-1:0] ra0,
  input  logic [REG_ADDR_WIDTH-1:0] ra1,
  input  logic [REG_ADDR_WIDTH-1:0] wa,
  input  logic                      wr_en,
  input  logic                      jump,
  output logic [XLEN-1:0]           rd0,
  output logic [XLEN-1:0]           rd1,
  output logic [XLEN-1:0]           alu_result,
  output logic                      alu_zero,
  output logic [XLEN-1:0]           pc
);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic [XLEN-1:0] r_pc;

  logic [XLEN-1:0] w_rd0;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_alu_result;
  logic            w_alu_zero;
  logic [XLEN-1:0] w_pc_next;

  // Entry 0 is never written; the read muxes force x0 to zero regardless.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en && (wa != '0)) begin
      r_regs[wa] <= wdata_in;
    end
  end

  // Combinational reads with no write bypass: a same-cycle read sees the old value.
  assign w_rd0 = (ra0 == '0) ? '0 : r_regs[ra0];
  assign w_rd1 = (ra1 == '0) ? '0 : r_regs[ra1];

  rv32i_alu u_alu (
    .a      (w_rd0),
    .b      (w_rd1),
    .op     (alu_op_e'(alu_test)),
    .result (w_alu_result),
    .zero   (w_alu_zero)
  );

  // Jump targets are forced halfword-aligned by clearing bit 0.
  assign w_pc_next = jump ? (w_alu_result & ~32'h1) : (r_pc + 32'd4);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign rd0        = w_rd0;
  assign rd1        = w_rd1;
  assign alu_result = w_alu_result;
  assign alu_zero   = w_alu_zero;
  assign pc         = r_pc;

endmodule

// File: tb/tb_rv32i_core_top.sv
// tb/tb_rv32i_core_top.sv - directed self-checking bench for rv32i_core_top
module tb_rv32i_core_top;

  logic        clk = 1'b0;
  logic        areset_n = 1'b1;
  logic [31:0] wdata_in = '0;
  logic [3:0]  alu_test = '0;
  logic [4:0]  ra0 = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  wa = '0;
  logic        wr_en = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] rd0;
  logic [31:0] rd1;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_core_top #(.RESET_VECTOR(32'h0)) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .wdata_in   (wdata_in),
    .alu_test   (alu_test),
    .ra0        (ra0),
    .ra1        (ra1),
    .wa         (wa),
    .wr_en      (wr_en),
    .jump       (jump),
    .rd0        (rd0),
    .rd1        (rd1),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .pc         (pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: one-cycle register write.
  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    wa = addr;
    wdata_in = data;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    #1 areset_n = 1'b0;
    #49;
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc got %h exp %h", pc, 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i);
      ra1 = 5'(31 - i);
      #1;
      checks++;
      if (rd0 !== 32'h0 || rd1 !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd ra0=%0d got rd0=%h rd1=%h exp 0", i, rd0, rd1);
      end
    end
    @(negedge clk);
    areset_n = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h4) begin
      errors++;
      $display("FAIL reset_release_pc got %h exp %h", pc, 32'h4);
    end
  endtask

  task automatic test_regfile_write();
    write_reg(5'd1, 32'd20);
    write_reg(5'd2, 32'd30);
    ra0 = 5'd1;
    ra1 = 5'd2;
    #1;
    checks++;
    if (rd0 !== 32'd20 || rd1 !== 32'd30) begin
      errors++;
      $display("FAIL regfile_rw got rd0=%0d rd1=%0d exp 20 30", rd0, rd1);
    end
  endtask

  task automatic test_no_bypass();
    ra0 = 5'd1;
    wa = 5'd1;
    wdata_in = 32'd99;
    wr_en = 1'b1;
    #1;
    checks++;
    if (rd0 !== 32'd20) begin
      errors++;
      $display("FAIL no_bypass_old got %0d exp %0d", rd0, 20);
    end
    tick();
    wr_en = 1'b0;
    checks++;
    if (rd0 !== 32'd99) begin
      errors++;
      $display("FAIL no_bypass_new got %0d exp %0d", rd0, 99);
    end
    write_reg(5'd1, 32'd20);
  endtask

  task automatic test_x0_write();
    write_reg(5'd0, 32'd20);
    ra0 = 5'd0;
    alu_test = 4'd10;
    #1;
    checks++;
    if (rd0 !== 32'h0 || alu_result !== 32'h0 || alu_zero !== 1'b1) begin
      errors++;
      $display("FAIL x0_write got rd0=%h res=%h zero=%b exp 0 0 1", rd0, alu_result, alu_zero);
    end
  endtask

  task automatic test_alu_sweep();
    logic [31:0] exp_tab [16];
    exp_tab = '{32'd50, 32'hFFFF_FFF6, 32'd0, 32'd1, 32'd1, 32'd10, 32'd0, 32'd0,
                32'd30, 32'd20, 32'd20, 32'd30, 32'd0, 32'd1, 32'd0, 32'd0};
    ra0 = 5'd1;
    ra1 = 5'd2;
    for (int i = 0; i < 16; i++) begin
      alu_test = 4'(i);
      #1;
      checks++;
      if (alu_result !== exp_tab[i] || alu_zero !== (exp_tab[i] == 32'h0)) begin
        errors++;
        $display("FAIL alu_op%0d got %h zero=%b exp %h", i, alu_result, alu_zero, exp_tab[i]);
      end
    end
  endtask

  task automatic test_alu_signed();
    logic [31:0] exp_tab [16];
    // A = 0x8000_0000 (most negative), B = 4
    exp_tab = '{32'h8000_0004, 32'h7FFF_FFFC, 32'h0, 32'd1, 32'd0, 32'h8000_0004,
                32'h0800_0000, 32'hF800_0000, 32'h8000_0004, 32'h0, 32'h8000_0000,
                32'd4, 32'd0, 32'd1, 32'd0, 32'd1};
    write_reg(5'd3, 32'h8000_0000);
    write_reg(5'd4, 32'd4);
    ra0 = 5'd3;
    ra1 = 5'd4;
    for (int i = 0; i < 16; i++) begin
      alu_test = 4'(i);
      #1;
      checks++;
      if (alu_result !== exp_tab[i]) begin
        errors++;
        $display("FAIL alu_signed_op%0d got %h exp %h", i, alu_result, exp_tab[i]);
      end
    end
  endtask

  task automatic test_jump();
    ra0 = 5'd1;
    ra1 = 5'd2;
    alu_test = 4'd0;
    jump = 1'b1;
    tick();
    jump = 1'b0;
    checks++;
    if (pc !== 32'd50) begin
      errors++;
      $display("FAIL jump_target got %0d exp %0d", pc, 50);
    end
    tick();
    checks++;
    if (pc !== 32'd54) begin
      errors++;
      $display("FAIL jump_plus4 got %0d exp %0d", pc, 54);
    end
    tick();
    checks++;
    if (pc !== 32'd58) begin
      errors++;
      $display("FAIL jump_plus8 got %0d exp %0d", pc, 58);
    end
  endtask

  task automatic test_jump_odd_with_write();
    write_reg(5'd5, 32'd51);
    ra0 = 5'd5;
    ra1 = 5'd6;
    alu_test = 4'd10;
    wa = 5'd6;
    wdata_in = 32'd7;
    wr_en = 1'b1;
    jump = 1'b1;
    tick();
    wr_en = 1'b0;
    jump = 1'b0;
    checks++;
    if (pc !== 32'd50) begin
      errors++;
      $display("FAIL jump_odd_pc got %0d exp %0d", pc, 50);
    end
    checks++;
    if (rd1 !== 32'd7) begin
      errors++;
      $display("FAIL jump_with_write got %0d exp %0d", rd1, 7);
    end
  endtask

  task automatic test_pc_wrap();
    write_reg(5'd7, 32'hFFFF_FFFC);
    ra0 = 5'd7;
    alu_test = 4'd10;
    jump = 1'b1;
    tick();
    jump = 1'b0;
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_target got %h exp %h", pc, 32'hFFFF_FFFC);
    end
    tick();
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap got %h exp %h", pc, 32'h0);
    end
  endtask

  task automatic test_midrun_reset();
    @(posedge clk);
    #2 areset_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL midrun_pc got %h exp %h", pc, 32'h0);
    end
    for (int i = 1; i < 32; i++) begin
      ra0 = 5'(i);
      #0.1;
      checks++;
      if (rd0 !== 32'h0) begin
        errors++;
        $display("FAIL midrun_reg x%0d got %h exp 0", i, rd0);
      end
    end
    @(negedge clk);
    areset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (pc !== 32'(4 * k)) begin
        errors++;
        $display("FAIL midrun_count%0d got %h exp %h", k, pc, 32'(4 * k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_regfile_write();
    test_no_bypass();
    test_x0_write();
    test_alu_sweep();
    test_alu_signed();
    test_jump();
    test_jump_odd_with_write();
    test_pc_wrap();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
